// File: rtl/alu_op_issuer.sv
// -----------------------------------------------------------------------------
// alu_op_issuer
// Initiator for an E-gated combinational ALU. A request (A, B, func) taken on
// the valid/ready request port is registered onto alu_a/alu_b/alu_func. alu_e
// is then held high for SETTLE_CYCLES cycles (0 is treated as 1). The ALU
// result and overflow are captured and returned on a valid/ready response port.
//
// Ports
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready     request handshake (ready only while idle)
//   req_a/req_b/req_func    request operands and function select
//   alu_a/alu_b/alu_func    registered operands and function select to the ALU
//   alu_e                   ALU enable
//   alu_c/alu_ovf           ALU result and overflow, sampled at the capture edge
//   rsp_valid/rsp_ready     response handshake
//   rsp_c/rsp_ovf           captured result and overflow
//   ovf_sticky              set by any captured overflow, cleared only by reset
//   busy                    high whenever the issuer is not idle
//   op_count                completed response handshakes, wraps to 0
// -----------------------------------------------------------------------------
module alu_op_issuer #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned FUNC_WIDTH    = 4,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned COUNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [DATA_WIDTH-1:0]  req_a,
    input  logic [DATA_WIDTH-1:0]  req_b,
    input  logic [FUNC_WIDTH-1:0]  req_func,
    output logic [DATA_WIDTH-1:0]  alu_a,
    output logic [DATA_WIDTH-1:0]  alu_b,
    output logic [FUNC_WIDTH-1:0]  alu_func,
    output logic                   alu_e,
    input  logic [DATA_WIDTH-1:0]  alu_c,
    input  logic                   alu_ovf,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_c,
    output logic                   rsp_ovf,
    output logic                   ovf_sticky,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] op_count
);

    localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
    localparam int unsigned CNT_W      = (SETTLE_EFF < 2) ? 1 : $clog2(SETTLE_EFF + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_EFF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  a_q, a_d;
    logic [DATA_WIDTH-1:0]  b_q, b_d;
    logic [FUNC_WIDTH-1:0]  func_q, func_d;
    logic                   e_q, e_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_c_q, rsp_c_d;
    logic                   rsp_ovf_q, rsp_ovf_d;
    logic                   sticky_q, sticky_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            func_q      <= '0;
            e_q         <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_c_q     <= '0;
            rsp_ovf_q   <= 1'b0;
            sticky_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            func_q      <= func_d;
            e_q         <= e_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_c_q     <= rsp_c_d;
            rsp_ovf_q   <= rsp_ovf_d;
            sticky_q    <= sticky_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        func_d      = func_q;
        e_d         = e_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_c_d     = rsp_c_q;
        rsp_ovf_d   = rsp_ovf_q;
        sticky_d    = sticky_q;
        count_d     = count_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    func_d  = req_func;
                    e_d     = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Last settle cycle: the ALU output has been stable long enough to sample.
                if (cnt_q == CNT_W'(1)) begin
                    rsp_c_d     = alu_c;
                    rsp_ovf_d   = alu_ovf;
                    sticky_d    = sticky_q | alu_ovf;
                    e_d         = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    count_d     = count_q + COUNT_WIDTH'(1);
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_func   = func_q;
    assign alu_e      = e_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_c      = rsp_c_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign ovf_sticky = sticky_q;
    assign op_count   = count_q;

endmodule
